// File: rtl/store_buffer_pkg.sv
// Shared store-buffer types: word-address width and the {addr, data} entry layout.
// Entry addresses hold byte-address bits [15:2] only.
package store_buffer_pkg;

    localparam int DATA_W  = 32;
    localparam int WADDR_W = 14;

    typedef logic [WADDR_W-1:0] waddr_t;

    typedef struct packed {
        waddr_t              addr;
        logic [DATA_W-1:0]   data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// Youngest-match search over the valid entries, walking from head (oldest) to tail.
// Purely combinational; no backpressure.
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic [PW-1:0] head,
    input  logic [CW-1:0] count,
    input  waddr_t        ent_addr [DEPTH],
    input  waddr_t        ld_waddr,
    output logic          hit,
    output logic [PW-1:0] sel
);

    always_comb begin : search
        logic [PW-1:0] idx;
        idx = '0;
        hit = 1'b0;
        sel = head;
        // Later offsets overwrite earlier ones, so the youngest match wins.
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if ((CW'(k) < count) && (ent_addr[idx] == ld_waddr)) begin
                hit = 1'b1;
                sel = idx;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer FIFO draining to the data-memory write port; loads are matched (forwarded with STORE_BUF_FWD_EN, else stalled).
// Push-to-mem_we latency 1 cycle; st_ready drops when full, drain waits while mem_busy is high.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = store_buffer_pkg::DATA_W,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [31:0]       st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [31:0]       ld_addr,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_stall,
    input  logic              mem_busy,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              empty,
    output logic [CW-1:0]     count
);

    import store_buffer_pkg::*;

    waddr_t            ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic              push;
    logic              pop;
    logic              match_hit;
    logic [PW-1:0]     match_sel;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{st_addr[31:16], st_addr[1:0], ld_addr[31:16], ld_addr[1:0]};

    // A full buffer refuses pushes even when the head drains this cycle.
    assign empty     = (count == '0);
    assign st_ready  = (count != CW'(DEPTH));
    assign push      = st_valid && st_ready;
    assign mem_we    = !empty && !mem_busy;
    assign pop       = mem_we;
    assign mem_addr  = {16'b0, ent_addr[head], 2'b00};
    assign mem_wdata = ent_data[head];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            if (push) begin
                ent_addr[tail] <= st_addr[15:2];
                ent_data[tail] <= st_data;
                tail           <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // The incoming store is not yet in the array, so it never matches its own cycle's load.
    store_buffer_match #(.DEPTH(DEPTH)) u_match (
        .head     (head),
        .count    (count),
        .ent_addr (ent_addr),
        .ld_waddr (ld_addr[15:2]),
        .hit      (match_hit),
        .sel      (match_sel)
    );

`ifdef STORE_BUF_FWD_EN
    assign ld_hit   = match_hit;
    assign ld_data  = match_hit ? ent_data[match_sel] : '0;
    assign ld_stall = 1'b0;
`else
    logic [PW-1:0] unused_sel;
    assign unused_sel = match_sel;
    assign ld_hit     = 1'b0;
    assign ld_data    = '0;
    assign ld_stall   = match_hit;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_store_buffer;

    import store_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          st_valid;
    logic          st_ready;
    logic [31:0]   st_addr;
    logic [DW-1:0] st_data;
    logic [31:0]   ld_addr;
    logic          ld_hit;
    logic [DW-1:0] ld_data;
    logic          ld_stall;
    logic          mem_busy;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          empty;
    logic [CW-1:0] count;

    sb_entry_t q[$];
    int n_chk;
    int n_err;

    store_buffer #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .ld_addr   (ld_addr),
        .ld_hit    (ld_hit),
        .ld_data   (ld_data),
        .ld_stall  (ld_stall),
        .mem_busy  (mem_busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .empty     (empty),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_outputs();
        int            sz;
        logic          exp_we;
        logic          found;
        logic [DW-1:0] fdata;
        sz     = q.size();
        exp_we = (sz != 0) && !mem_busy;
        chk("st_ready", 64'(st_ready), 64'(sz != DEPTH));
        chk("empty",    64'(empty),    64'(sz == 0));
        chk("count",    64'(count),    64'(sz));
        chk("mem_we",   64'(mem_we),   64'(exp_we));
        if (exp_we) begin
            chk("mem_addr",  64'(mem_addr),  64'({16'b0, q[0].addr, 2'b00}));
            chk("mem_wdata", 64'(mem_wdata), 64'(q[0].data));
        end
        found = 1'b0;
        fdata = '0;
        for (int i = 0; i < sz; i++) begin
            if (q[i].addr == ld_addr[15:2]) begin
                found = 1'b1;
                fdata = q[i].data;
            end
        end
`ifdef STORE_BUF_FWD_EN
        chk("ld_hit",   64'(ld_hit),   64'(found));
        chk("ld_data",  64'(ld_data),  64'(fdata));
        chk("ld_stall", 64'(ld_stall), 64'(0));
`else
        chk("ld_hit",   64'(ld_hit),   64'(0));
        chk("ld_data",  64'(ld_data),  64'(0));
        chk("ld_stall", 64'(ld_stall), 64'(found));
`endif
    endtask

    task automatic step(input logic v, input logic [31:0] a, input logic [DW-1:0] d,
                        input logic [31:0] la, input logic busy);
        logic      do_push;
        logic      do_pop;
        sb_entry_t e;
        @(negedge clk);
        st_valid = v;
        st_addr  = a;
        st_data  = d;
        ld_addr  = la;
        mem_busy = busy;
        #1 check_outputs();
        do_push = v && (q.size() != DEPTH);
        do_pop  = (q.size() != 0) && !busy;
        @(posedge clk);
        if (do_pop) q.delete(0);
        if (do_push) begin
            e.addr = a[15:2];
            e.data = d;
            q.push_back(e);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_mem_we"},   64'(mem_we),   64'(0));
        chk({tag, "_st_ready"}, 64'(st_ready), 64'(1));
        chk({tag, "_empty"},    64'(empty),    64'(1));
        chk({tag, "_count"},    64'(count),    64'(0));
        chk({tag, "_ld_hit"},   64'(ld_hit),   64'(0));
        chk({tag, "_ld_stall"}, 64'(ld_stall), 64'(0));
    endtask

    // Reset asserted between edges; the buffer must go idle immediately and write nothing.
    task automatic reset_mid(input logic [31:0] la);
        @(negedge clk);
        rst      = 1'b0;
        st_valid = 1'b0;
        mem_busy = 1'b0;
        ld_addr  = la;
        #1 check_reset_state("rst_now");
        @(posedge clk);
        #1 chk("rst_edge_mem_we", 64'(mem_we), 64'(0));
        @(negedge clk);
        check_reset_state("rst_hold");
        rst = 1'b1;
        q.delete();
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rl;
        n_chk    = 0;
        n_err    = 0;
        rst      = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        ld_addr  = '0;
        mem_busy = 1'b0;
        #1 check_reset_state("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Single store into an empty buffer drains one cycle later.
        step(1, 32'h10, 32'hA5A5_A5A5, 32'h0, 0);
        step(0, 32'h0, 32'h0, 32'h10, 0);
        step(0, 32'h0, 32'h0, 32'h0, 0);

        // Fill while memory is busy; fifth store refused; then in-order drain.
        for (int i = 0; i < 5; i++) step(1, 32'h100 + 32'(i * 4), 32'hB000 + 32'(i), 32'h0, 1);
        step(0, 32'h0, 32'h0, 32'h0, 1);
        for (int i = 0; i < 5; i++) step(0, 32'h0, 32'h0, 32'h108, 0);

        // Two stores to one word: youngest forwarded; upper address bits ignored.
        step(1, 32'h20, 32'h1111, 32'h0, 1);
        step(1, 32'h20, 32'h2222, 32'h20, 1);
        step(0, 32'h0, 32'h0, 32'h22, 1);
        step(0, 32'h0, 32'h0, 32'h10020, 1);
        step(0, 32'h0, 32'h0, 32'h20, 0);
        step(0, 32'h0, 32'h0, 32'h20, 0);
        step(0, 32'h0, 32'h0, 32'h20, 0);

        // A store is invisible to a load in the cycle it is presented.
        step(1, 32'h40, 32'h4444, 32'h40, 1);
        step(0, 32'h0, 32'h0, 32'h40, 0);

        // Full buffer: pop plus st_valid pushes nothing; next cycle the push lands.
        for (int i = 0; i < 4; i++) step(1, 32'h200 + 32'(i * 4), 32'hC000 + 32'(i), 32'h0, 1);
        step(1, 32'h300, 32'hDEAD, 32'h0, 0);
        step(1, 32'h300, 32'hBEEF, 32'h300, 1);
        step(0, 32'h0, 32'h0, 32'h300, 1);
        for (int i = 0; i < 4; i++) step(0, 32'h0, 32'h0, 32'h0, 0);

        // Reset with three stores pending.
        for (int i = 0; i < 3; i++) step(1, 32'h400 + 32'(i * 4), 32'hE000 + 32'(i), 32'h0, 1);
        reset_mid(32'h404);
        step(0, 32'h0, 32'h0, 32'h404, 0);
        step(0, 32'h0, 32'h0, 32'h0, 0);

        // Random traffic over a small address pool to provoke matches.
        for (int n = 0; n < 400; n++) begin
            ra = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 5)) << 2) | 32'($urandom_range(0, 3));
            rl = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 5)) << 2) | 32'($urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), ra, $urandom, rl, ($urandom_range(0, 99) < 40));
        end
        for (int i = 0; i < DEPTH + 1; i++) step(0, 32'h0, 32'h0, 32'h0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, 2..16).
REQ-002 SHALL have parameter DATA_W, default 32, store data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port st_valid  input  1  pipeline presents a store this cycle.
REQ-006 SHALL have port st_ready  output  1  buffer can accept a store.
REQ-007 SHALL have port st_addr  input  32  store byte address; only bits [15:2] significant.
REQ-008 SHALL have port st_data  input  DATA_W  store data.
REQ-009 SHALL have port ld_addr  input  32  address of the load in the memory stage this cycle.
REQ-010 SHALL have port ld_hit  output  1  ld_data holds forwarded buffered data.
REQ-011 SHALL have port ld_data  output  DATA_W  forwarded data.
REQ-012 SHALL have port ld_stall  output  1  load must wait for drain.
REQ-013 SHALL have port mem_busy  input  1  data-memory port is used by a load this cycle.
REQ-014 SHALL have ports mem_we (output, 1), mem_addr (output, 32) and mem_wdata (output, DATA_W), which drive the data memory write port.
REQ-015 SHALL have ports empty (output, 1) and count (output, $clog2(DEPTH)+1), which give occupancy.

Function
REQ-016 SHALL be a FIFO of {word address [15:2], data} entries with head/tail pointers that wrap modulo DEPTH.
REQ-017 SHALL set st_ready = (count != DEPTH), combinationally; a push occurs on the edge where st_valid && st_ready.
REQ-018 SHALL drive mem_we = !empty && !mem_busy combinationally, with mem_addr = {16'b0, head_addr, 2'b00} and mem_wdata = head data.
REQ-019 SHALL pop the head on the same edge at which mem_we is high; memory captures the write on that edge.
REQ-020 SHALL keep count unchanged on simultaneous push and pop; with no pop, count SHALL increment on push; with no push, count SHALL decrement on pop.
REQ-021 SHALL, when full, accept no push in a cycle even if a pop occurs in that cycle (no full-bypass).
REQ-022 SHALL give a store pushed into an empty buffer a minimum latency of one cycle to its mem_we.
REQ-023 SHALL define a match as a valid entry whose word address equals ld_addr[15:2], with bits [31:16] ignored.
REQ-024 SHALL include the head entry in match search in the cycle it drains.
REQ-025 SHALL keep a store presented on st_valid invisible to ld_addr matching in that same cycle.
REQ-026 SHALL, on multiple matches, select the youngest (closest to tail) entry.
REQ-027 SHALL hold mem_we at 0 indefinitely while mem_busy stays high, with contents held.

Reset
REQ-028 SHALL, while rst=0, clear pointers, count and all entries to 0.
REQ-029 SHALL, while rst=0, hold st_ready=1, empty=1, mem_we=0, ld_hit=0 and ld_stall=0.
REQ-030 SHALL, on reset mid-operation, discard undrained stores, with no memory write on the reset edge.

Configuration
REQ-031 SHALL, with STORE_BUF_FWD_EN defined, drive ld_hit = match, ld_data = youngest matching data and ld_stall = 0.
REQ-032 SHALL, without STORE_BUF_FWD_EN, drive ld_hit = 0, ld_data = 0 and ld_stall = match.

Structure
REQ-033 SHALL place DATA_W, the word-address width (14) and the entry typedef {addr, data} in package store_buffer_pkg.
REQ-034 SHALL implement the youngest-match priority search as sub-module store_buffer_match.

Verification
REQ-035 SHALL cover: push st_addr=0x10, data=0xA5A5A5A5 into an empty buffer, mem_busy=0 -> next cycle mem_we=1, mem_addr=0x10; after that edge, empty=1.
REQ-036 SHALL cover: mem_busy=1, push 5 stores with DEPTH=4 -> 4 accepted, st_ready=0 on the 5th, count=4; release mem_busy -> drains in order, one per cycle.
REQ-037 SHALL cover: buffer holds 0x20<-0x1111 then 0x20<-0x2222, ld_addr=0x22 -> ld_hit=1, ld_data=0x2222 (FWD_EN); ld_stall=1 (without FWD_EN).
REQ-038 SHALL cover: ld_addr=0x10020 against an entry at 0x20 -> match, since the upper bits are ignored.
REQ-039 SHALL cover: full buffer with simultaneous pop and st_valid -> no push; push accepted next cycle, count=4.
REQ-040 SHALL cover: rst asserted with 3 entries pending -> mem_we=0 immediately; after release, empty=1, count=0, no writes.
